// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if
//   Bundles the pixel-side signals of the VGA timing generator.
//   master modport : the timing generator (drives the outputs below, takes pix_en/color_in)
//   slave modport  : frame-buffer reader / DAC side
//   Signals:
//     pix_en        pixel clock enable (slave -> master)
//     color_in      {R,G,B}, one COLOR_W field each, for the pixel requested PIPE enabled ticks earlier
//     next_x/next_y requested pixel coordinate, 0 outside the active region
//     hsync/vsync   sync outputs at the configured polarity
//     red/green/blue colour outputs, 0 outside active video
//     blank         high during active video
//     sync          constant 0
//     clk           copy of the pixel clock
//     line_start/frame_start  one-clock strobes on the counter timeline
//     frame_count   completed frames, free-running 16-bit
//     h_phase/v_phase  debug view of the horizontal / vertical phase FSMs
//   Flow control: pix_en is the only qualifier. Every rising clock edge with
//   pix_en=1 consumes one color_in word and advances one pixel; there is no
//   back-pressure, so the source must present valid colour on every enabled tick.
interface vga_timing_gen_if #(
  parameter int COLOR_W = 8
) ();
  logic                   pix_en;
  logic [3*COLOR_W-1:0]   color_in;
  logic [10:0]            next_x;
  logic [10:0]            next_y;
  logic                   hsync;
  logic                   vsync;
  logic [COLOR_W-1:0]     red;
  logic [COLOR_W-1:0]     green;
  logic [COLOR_W-1:0]     blue;
  logic                   blank;
  logic                   sync;
  logic                   clk;
  logic                   line_start;
  logic                   frame_start;
  logic [15:0]            frame_count;
  logic [1:0]             h_phase;
  logic [1:0]             v_phase;

  modport master (
    input  pix_en, color_in,
    output next_x, next_y, hsync, vsync, red, green, blue, blank, sync, clk,
           line_start, frame_start, frame_count, h_phase, v_phase
  );

  modport slave (
    output pix_en, color_in,
    input  next_x, next_y, hsync, vsync, red, green, blue, blank, sync, clk,
           line_start, frame_start, frame_count, h_phase, v_phase
  );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Programmable VGA timing generator and pixel output stage.
//   Ports:
//     clock  pixel-rate clock
//     reset  asynchronous, active-high
//     vga    vga_timing_gen_if.master: pix_en/color_in in; coordinates, syncs,
//            colour, blank, strobes, frame counter and phase debug out
//   h_cnt/v_cnt walk the raster; horizontal and vertical phase FSMs track
//   ACTIVE/FRONT/PULSE/BACK. The per-pixel {active, hs, vs} flags travel down a
//   PIPE-deep delay line so sync/blank meet the colour that the upstream fetch
//   returns PIPE enabled ticks after the request.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int H_PULSE  = 96,
  parameter int H_BACK   = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int V_PULSE  = 2,
  parameter int V_BACK   = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int COLOR_W  = 8,
  parameter int PIPE     = 1
) (
  input logic              clock,
  input logic              reset,
  vga_timing_gen_if.master vga
);

  localparam int H_T = H_ACTIVE + H_FRONT + H_PULSE + H_BACK;
  localparam int V_T = V_ACTIVE + V_FRONT + V_PULSE + V_BACK;

  localparam logic [10:0] H_LAST     = 11'(H_T - 1);
  localparam logic [10:0] H_FRONT_AT = 11'(H_ACTIVE);
  localparam logic [10:0] H_PULSE_AT = 11'(H_ACTIVE + H_FRONT);
  localparam logic [10:0] H_BACK_AT  = 11'(H_ACTIVE + H_FRONT + H_PULSE);
  localparam logic [10:0] V_LAST     = 11'(V_T - 1);
  localparam logic [10:0] V_FRONT_AT = 11'(V_ACTIVE);
  localparam logic [10:0] V_PULSE_AT = 11'(V_ACTIVE + V_FRONT);
  localparam logic [10:0] V_BACK_AT  = 11'(V_ACTIVE + V_FRONT + V_PULSE);

  typedef enum logic [1:0] {
    PH_ACTIVE = 2'd0,
    PH_FRONT  = 2'd1,
    PH_PULSE  = 2'd2,
    PH_BACK   = 2'd3
  } phase_t;

  typedef struct packed {
    logic active;
    logic hs;
    logic vs;
  } tap_t;

  phase_t               h_phase;
  phase_t               v_phase;
  logic [10:0]          h_cnt;
  logic [10:0]          v_cnt;
  logic [10:0]          h_nxt;
  logic [10:0]          v_nxt;
  logic                 h_wrap;
  logic                 v_wrap;
  tap_t                 cur_tap;
  tap_t                 tail;
  tap_t                 dly [PIPE];

  logic                 hsync_q;
  logic                 vsync_q;
  logic                 blank_q;
  logic [COLOR_W-1:0]   red_q;
  logic [COLOR_W-1:0]   green_q;
  logic [COLOR_W-1:0]   blue_q;
  logic                 line_start_q;
  logic                 frame_start_q;
  logic [15:0]          frame_count_q;

  // The phase follows the counter value being loaded, so the phase register
  // always describes the coordinate currently held in the counter.
  function automatic phase_t step_phase(input phase_t ph, input logic [10:0] nxt,
                                        input logic [10:0] front_at,
                                        input logic [10:0] pulse_at,
                                        input logic [10:0] back_at);
    phase_t r;
    r = ph;
    case (ph)
      PH_ACTIVE: if (nxt == front_at) r = PH_FRONT;
      PH_FRONT:  if (nxt == pulse_at) r = PH_PULSE;
      PH_PULSE:  if (nxt == back_at)  r = PH_BACK;
      PH_BACK:   if (nxt == 11'd0)    r = PH_ACTIVE;
      default:   r = PH_ACTIVE;
    endcase
    return r;
  endfunction

  always_comb begin
    h_wrap         = (h_cnt == H_LAST);
    v_wrap         = (v_cnt == V_LAST);
    h_nxt          = h_wrap ? 11'd0 : h_cnt + 11'd1;
    v_nxt          = v_wrap ? 11'd0 : v_cnt + 11'd1;
    cur_tap.active = (h_phase == PH_ACTIVE) && (v_phase == PH_ACTIVE);
    cur_tap.hs     = (h_phase == PH_PULSE);
    cur_tap.vs     = (v_phase == PH_PULSE);
    tail           = dly[PIPE-1];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      h_cnt         <= 11'd0;
      v_cnt         <= 11'd0;
      h_phase       <= PH_ACTIVE;
      v_phase       <= PH_ACTIVE;
      for (int i = 0; i < PIPE; i++) dly[i] <= '0;
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      blank_q       <= 1'b0;
      red_q         <= '0;
      green_q       <= '0;
      blue_q        <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_count_q <= 16'd0;
    end else if (vga.pix_en) begin
      h_cnt   <= h_nxt;
      h_phase <= step_phase(h_phase, h_nxt, H_FRONT_AT, H_PULSE_AT, H_BACK_AT);
      if (h_wrap) begin
        v_cnt   <= v_nxt;
        v_phase <= step_phase(v_phase, v_nxt, V_FRONT_AT, V_PULSE_AT, V_BACK_AT);
      end

      dly[0] <= cur_tap;
      for (int i = 1; i < PIPE; i++) dly[i] <= dly[i-1];

      // color_in arriving now belongs to the pixel at the delay-line tail.
      hsync_q <= tail.hs ? HS_POL : ~HS_POL;
      vsync_q <= tail.vs ? VS_POL : ~VS_POL;
      blank_q <= tail.active;
      if (tail.active) begin
        red_q   <= vga.color_in[3*COLOR_W-1:2*COLOR_W];
        green_q <= vga.color_in[2*COLOR_W-1:COLOR_W];
        blue_q  <= vga.color_in[COLOR_W-1:0];
      end else begin
        red_q   <= '0;
        green_q <= '0;
        blue_q  <= '0;
      end

      // Strobes mark the counters being loaded with 0 (not the delayed pixel).
      line_start_q  <= h_wrap;
      frame_start_q <= h_wrap && v_wrap;
      if (h_wrap && v_wrap) frame_count_q <= frame_count_q + 16'd1;
    end else begin
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end
  end

  assign vga.next_x      = (h_phase == PH_ACTIVE) ? h_cnt : 11'd0;
  assign vga.next_y      = (v_phase == PH_ACTIVE) ? v_cnt : 11'd0;
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.blank       = blank_q;
  assign vga.red         = red_q;
  assign vga.green       = green_q;
  assign vga.blue        = blue_q;
  assign vga.sync        = 1'b0;
  assign vga.clk         = clock;
  assign vga.line_start  = line_start_q;
  assign vga.frame_start = frame_start_q;
  assign vga.frame_count = frame_count_q;
  assign vga.h_phase     = h_phase;
  assign vga.v_phase     = v_phase;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen
//   Two instances: dut_a (H 8/2/3/2, V 4/1/2/1, PIPE=3, active-low syncs) with
//   a gated pix_en, and dut_b (H 4/1/1/1, V 2/1/1/1, PIPE=1, active-high syncs)
//   with pix_en held high. Expected values come from a hand-computed vector
//   table and from a raster-index model (pixel n sits at h=n%H_T, v=n/H_T%V_T).
module tb_vga_timing_gen;

  logic clock;
  logic rst_a;
  logic rst_b;

  int checks   = 0;
  int failures = 0;

  int e_a = 0;           // enabled ticks seen by dut_a since reset release
  int e_b = 0;
  bit last_en_a = 1'b0;  // whether the most recent edge advanced dut_a

  vga_timing_gen_if #(.COLOR_W(8)) a_if ();
  vga_timing_gen_if #(.COLOR_W(8)) b_if ();

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FRONT(2), .H_PULSE(3), .H_BACK(2),
    .V_ACTIVE(4), .V_FRONT(1), .V_PULSE(2), .V_BACK(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .COLOR_W(8), .PIPE(3)
  ) dut_a (
    .clock(clock),
    .reset(rst_a),
    .vga(a_if.master)
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FRONT(1), .H_PULSE(1), .H_BACK(1),
    .V_ACTIVE(2), .V_FRONT(1), .V_PULSE(1), .V_BACK(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .COLOR_W(8), .PIPE(1)
  ) dut_b (
    .clock(clock),
    .reset(rst_b),
    .vga(b_if.master)
  );

  // ---------------- clock ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // ---------------- expected-value model ----------------
  typedef struct {
    logic [10:0] nx;
    logic [10:0] ny;
    logic        hs;
    logic        vs;
    logic        blank;
    logic        ls;
    logic        fs;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
    logic [15:0] fc;
  } exp_t;

  typedef struct {
    bit          en;
    logic [10:0] nx;
    logic [10:0] ny;
    logic        ls;
    logic        blank;
    logic        hs;
    logic [7:0]  red;
  } vec_t;

  function automatic exp_t model(input int ha, hf, hp, hb, va, vf, vp, vb,
                                 input bit hpol, vpol, input int pipe,
                                 input int e, input bit edge_en);
    exp_t x;
    int ht, vt, h, v, o, oh, ov;
    bit act;
    ht = ha + hf + hp + hb;
    vt = va + vf + vp + vb;
    h  = e % ht;
    v  = (e / ht) % vt;
    x.nx = (h < ha) ? 11'(h) : 11'd0;
    x.ny = (v < va) ? 11'(v) : 11'd0;
    x.ls = edge_en && (h == 0);
    x.fs = edge_en && (h == 0) && (v == 0);
    x.fc = 16'((e / (ht * vt)) % 65536);
    o = e - 1 - pipe;
    if (o < 0) begin
      x.blank = 1'b0;
      x.hs    = ~hpol;
      x.vs    = ~vpol;
      x.r     = 8'd0;
      x.g     = 8'd0;
      x.b     = 8'd0;
    end else begin
      oh  = o % ht;
      ov  = (o / ht) % vt;
      act = (oh < ha) && (ov < va);
      x.blank = act;
      x.hs    = (oh >= ha + hf && oh < ha + hf + hp) ? hpol : ~hpol;
      x.vs    = (ov >= va + vf && ov < va + vf + vp) ? vpol : ~vpol;
      x.r     = act ? 8'(oh) : 8'd0;
      x.g     = act ? 8'(ov) : 8'd0;
      x.b     = act ? 8'h55 : 8'd0;
    end
    return x;
  endfunction

  // Colour the upstream fetch returns for the edge about to happen: the pixel
  // requested pipe enabled ticks earlier, or junk when that pixel is not visible.
  function automatic logic [23:0] pix_color(input int ha, ht, va, vt, pipe, e);
    int p, h, v;
    p = e - pipe;
    if (p >= 0) begin
      h = p % ht;
      v = (p / ht) % vt;
      if (h < ha && v < va) return {8'(h), 8'(v), 8'h55};
    end
    return 24'($urandom);
  endfunction

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_dut(input string tag, input exp_t x,
                           input logic [10:0] nx, ny,
                           input logic hs, vs, bl, ls, fs, sy, ck,
                           input logic [7:0] r, g, b, input logic [15:0] fc);
    chk({tag, ".next_x"},      32'(nx), 32'(x.nx));
    chk({tag, ".next_y"},      32'(ny), 32'(x.ny));
    chk({tag, ".hsync"},       32'(hs), 32'(x.hs));
    chk({tag, ".vsync"},       32'(vs), 32'(x.vs));
    chk({tag, ".blank"},       32'(bl), 32'(x.blank));
    chk({tag, ".line_start"},  32'(ls), 32'(x.ls));
    chk({tag, ".frame_start"}, 32'(fs), 32'(x.fs));
    chk({tag, ".red"},         32'(r),  32'(x.r));
    chk({tag, ".green"},       32'(g),  32'(x.g));
    chk({tag, ".blue"},        32'(b),  32'(x.b));
    chk({tag, ".frame_count"}, 32'(fc), 32'(x.fc));
    chk({tag, ".sync"},        32'(sy), 32'd0);
    chk({tag, ".clk"},         32'(ck), 32'(clock));
  endtask

  task automatic check_a();
    exp_t x;
    x = model(8, 2, 3, 2, 4, 1, 2, 1, 1'b0, 1'b0, 3, e_a, last_en_a);
    check_dut("a", x, a_if.next_x, a_if.next_y, a_if.hsync, a_if.vsync, a_if.blank,
              a_if.line_start, a_if.frame_start, a_if.sync, a_if.clk,
              a_if.red, a_if.green, a_if.blue, a_if.frame_count);
  endtask

  task automatic check_b(input bit edge_en);
    exp_t x;
    x = model(4, 1, 1, 1, 2, 1, 1, 1, 1'b1, 1'b1, 1, e_b, edge_en);
    check_dut("b", x, b_if.next_x, b_if.next_y, b_if.hsync, b_if.vsync, b_if.blank,
              b_if.line_start, b_if.frame_start, b_if.sync, b_if.clk,
              b_if.red, b_if.green, b_if.blue, b_if.frame_count);
  endtask

  // ---------------- driver ----------------
  // Drives inputs on the falling edge, returns 1 time unit after the rising edge.
  task automatic tick(input bit en_a);
    @(negedge clock);
    a_if.pix_en   = en_a;
    a_if.color_in = pix_color(8, 15, 4, 8, 3, e_a);
    b_if.pix_en   = 1'b1;
    b_if.color_in = pix_color(4, 7, 2, 5, 1, e_b);
    @(posedge clock);
    last_en_a = en_a && !rst_a;
    if (last_en_a) e_a++;
    if (!rst_b) e_b++;
    #1;
    check_b(!rst_b);
  endtask

  // ---------------- test ----------------
  vec_t vecs [19];

  initial begin
    int ls_cycle_prev;
    int ls_cycle_last;
    int ls_seen;
    bit found;

    // Hand-computed first 19 edges of dut_a after reset release.
    //           en    next_x  next_y  ls    blank hsync red
    vecs[0]  = '{1'b1, 11'd1, 11'd0, 1'b0, 1'b0, 1'b1, 8'd0};
    vecs[1]  = '{1'b1, 11'd2, 11'd0, 1'b0, 1'b0, 1'b1, 8'd0};
    vecs[2]  = '{1'b1, 11'd3, 11'd0, 1'b0, 1'b0, 1'b1, 8'd0};
    vecs[3]  = '{1'b1, 11'd4, 11'd0, 1'b0, 1'b1, 1'b1, 8'd0};
    vecs[4]  = '{1'b0, 11'd4, 11'd0, 1'b0, 1'b1, 1'b1, 8'd0};
    vecs[5]  = '{1'b1, 11'd5, 11'd0, 1'b0, 1'b1, 1'b1, 8'd1};
    vecs[6]  = '{1'b1, 11'd6, 11'd0, 1'b0, 1'b1, 1'b1, 8'd2};
    vecs[7]  = '{1'b1, 11'd7, 11'd0, 1'b0, 1'b1, 1'b1, 8'd3};
    vecs[8]  = '{1'b1, 11'd0, 11'd0, 1'b0, 1'b1, 1'b1, 8'd4};
    vecs[9]  = '{1'b1, 11'd0, 11'd0, 1'b0, 1'b1, 1'b1, 8'd5};
    vecs[10] = '{1'b1, 11'd0, 11'd0, 1'b0, 1'b1, 1'b1, 8'd6};
    vecs[11] = '{1'b1, 11'd0, 11'd0, 1'b0, 1'b1, 1'b1, 8'd7};
    vecs[12] = '{1'b1, 11'd0, 11'd0, 1'b0, 1'b0, 1'b1, 8'd0};
    vecs[13] = '{1'b1, 11'd0, 11'd0, 1'b0, 1'b0, 1'b1, 8'd0};
    vecs[14] = '{1'b1, 11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[15] = '{1'b1, 11'd0, 11'd1, 1'b1, 1'b0, 1'b0, 8'd0};
    vecs[16] = '{1'b0, 11'd0, 11'd1, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[17] = '{1'b1, 11'd1, 11'd1, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[18] = '{1'b1, 11'd2, 11'd1, 1'b0, 1'b0, 1'b1, 8'd0};

    // Reset state, including an enabled edge while reset is held.
    rst_a = 1'b1;
    rst_b = 1'b1;
    a_if.pix_en   = 1'b0;
    a_if.color_in = '0;
    b_if.pix_en   = 1'b0;
    b_if.color_in = '0;
    #12;
    check_a();
    check_b(1'b0);
    tick(1'b1);
    check_a();
    rst_a = 1'b0;
    rst_b = 1'b0;

    // Directed table.
    foreach (vecs[i]) begin
      tick(vecs[i].en);
      chk($sformatf("vec%0d.next_x", i),     32'(a_if.next_x),     32'(vecs[i].nx));
      chk($sformatf("vec%0d.next_y", i),     32'(a_if.next_y),     32'(vecs[i].ny));
      chk($sformatf("vec%0d.line_start", i), 32'(a_if.line_start), 32'(vecs[i].ls));
      chk($sformatf("vec%0d.blank", i),      32'(a_if.blank),      32'(vecs[i].blank));
      chk($sformatf("vec%0d.hsync", i),      32'(a_if.hsync),      32'(vecs[i].hs));
      chk($sformatf("vec%0d.red", i),        32'(a_if.red),        32'(vecs[i].red));
    end

    // More than two frames with a randomly gated pix_en.
    for (int i = 0; i < 400; i++) begin
      tick($urandom_range(0, 3) != 0);
      check_a();
    end
    chk("frames_done_a", 32'(a_if.frame_count >= 16'd2), 32'd1);

    // pix_en toggling 1,0,1,0: a 15-pixel line must take 30 clocks.
    ls_seen       = 0;
    ls_cycle_prev = 0;
    ls_cycle_last = 0;
    for (int i = 0; i < 70; i++) begin
      tick(i % 2 == 0);
      check_a();
      if (a_if.line_start === 1'b1) begin
        ls_cycle_prev = ls_cycle_last;
        ls_cycle_last = i;
        ls_seen++;
      end
    end
    chk("toggle_line_starts", 32'(ls_seen >= 2), 32'd1);
    chk("toggle_line_period", 32'(ls_cycle_last - ls_cycle_prev), 32'd30);

    // Seek h=5, v=2 (mid-line, visible) for an asynchronous reset.
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      tick(1'b1);
      check_a();
      found = ((e_a % 15) == 5) && (((e_a / 15) % 8) == 2);
    end
    chk("seek_midline", 32'(found), 32'd1);

    // Reset away from any clock edge: outputs must drop immediately.
    #2;
    rst_a     = 1'b1;
    e_a       = 0;
    last_en_a = 1'b0;
    #1;
    check_a();
    for (int i = 0; i < 3; i++) begin
      tick(1'b1);
      check_a();
    end
    rst_a = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick($urandom_range(0, 4) != 0);
      check_a();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
